// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N-channel push-button front end.
// Each channel: two-flop synchroniser, stability-counter debounce,
// press/release edge pulses and a hold FSM producing long-press and
// auto-repeat pulses. All outputs are registered.
//
// Hold FSM states (per channel):
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | key released, waiting for a debounced press
//   ST_SHORT | key pressed, counting towards the long-press threshold
//   ST_LONG  | long press reported, counting auto-repeat periods
module key_debounce_multi #(
  parameter int unsigned N_KEYS     = 5,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned CNT_MAX    = 20'hF_FFFF,
  parameter int unsigned LONG_CNT   = 50_000_000,
  parameter int unsigned REPEAT_CNT = 10_000_000,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam int unsigned HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int unsigned HW       = $clog2(HOLD_MAX);

  localparam logic [CW-1:0] CNT_MAX_V = CW'(CNT_MAX);
  localparam logic [HW-1:0] LONG_M1   = HW'(LONG_CNT - 1);
  localparam logic [HW-1:0] REP_M1    = HW'(REPEAT_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_LONG  = 2'd2
  } state_t;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic          r_s1;
    logic          r_s2;
    logic          r_p_d;
    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    logic          r_lvl_d;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          r_repeat;
    state_t        r_state;
    logic [HW-1:0] r_hold;

    logic          w_p;
    logic          w_stable;
    logic          w_rise;
    logic          w_fall;
    state_t        w_state_nx;
    logic [HW-1:0] w_hold_nx;
    logic          w_long_nx;
    logic          w_rep_nx;

    assign w_p      = r_s2 ^ ACTIVE_LOW;
    assign w_stable = (w_p == r_p_d);
    assign w_rise   = r_lvl & ~r_lvl_d;
    assign w_fall   = ~r_lvl & r_lvl_d;

    // Synchronise the pin, count stable cycles and update the debounced level.
    // The level only loads while p is unchanged, so a saturated counter left
    // over from the previous stable period cannot pass a fresh edge through.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        r_s1  <= ACTIVE_LOW;
        r_s2  <= ACTIVE_LOW;
        r_p_d <= 1'b0;
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else begin
        r_s1  <= key_in[g];
        r_s2  <= r_s1;
        r_p_d <= w_p;
        if (!w_stable) begin
          r_cnt <= '0;
        end else if (r_cnt != CNT_MAX_V) begin
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_stable && (r_cnt == CNT_MAX_V)) begin
          r_lvl <= w_p;
        end
      end
    end

    // Edge detect on the debounced level into registered press/release pulses.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        r_lvl_d   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_lvl_d   <= r_lvl;
        r_press   <= w_rise;
        r_release <= w_fall;
      end
    end

    // Hold FSM state, hold counter and registered long/repeat pulses.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        r_state  <= ST_IDLE;
        r_hold   <= '0;
        r_long   <= 1'b0;
        r_repeat <= 1'b0;
      end else begin
        r_state  <= w_state_nx;
        r_hold   <= w_hold_nx;
        r_long   <= w_long_nx;
        r_repeat <= w_rep_nx;
      end
    end

    // Next-state logic; a debounced release always beats a threshold hit.
    always_comb begin
      w_state_nx = r_state;
      w_hold_nx  = r_hold;
      w_long_nx  = 1'b0;
      w_rep_nx   = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nx = ST_SHORT;
            w_hold_nx  = '0;
          end
        end
        ST_SHORT: begin
          if (w_fall) begin
            w_state_nx = ST_IDLE;
            w_hold_nx  = '0;
          end else if (r_hold == LONG_M1) begin
            w_state_nx = ST_LONG;
            w_hold_nx  = '0;
            w_long_nx  = 1'b1;
          end else begin
            w_hold_nx = r_hold + HW'(1);
          end
        end
        ST_LONG: begin
          if (w_fall) begin
            w_state_nx = ST_IDLE;
            w_hold_nx  = '0;
          end else if (r_hold == REP_M1) begin
            // With repeat disabled the counter parks here: no wrap, no pulses.
            if (REPEAT_EN) begin
              w_rep_nx  = 1'b1;
              w_hold_nx = '0;
            end
          end else begin
            w_hold_nx = r_hold + HW'(1);
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_hold_nx  = '0;
        end
      endcase
    end

    assign key_level[g]   = r_lvl;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
    assign key_long[g]    = r_long;
    assign key_repeat[g]  = r_repeat;
  end

endmodule
